zeroriscy_vec_alu: RTL
======================

# zeroriscy_vec_alu

Multi-cycle, lane-parametrised vector ALU for the vector extension of the zero-riscy core. It accepts one vector instruction through a valid/ready handshake, processes `LANES` elements per cycle over `ceil(vl/LANES)` beats, and holds the buffered result vector until the writeback stage consumes it. It is the vector counterpart of the scalar ALU. It adds element-width parametrisation, scalar-broadcast operands, min/max, and a sum reduction.

## Interface
- `LANES`, 4: elements processed per EXEC cycle; power of two, 1..`MAX_VL`.
- `ELEN`, 32: element width in bits; power of two, 8..64.
- `MAX_VL`, 16: maximum vector length; multiple of `LANES`.
- `clk`  in  1  clock.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `in_valid_i`  in  1  request valid.
- `in_ready_o`  out  1  block can accept a request.
- `vop_i`  in  4  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLTS, 9 SLTU, 10 MINS, 11 MAXS, 12 MINU, 13 MAXU, 14 REDSUM; 15 is reserved and produces 0.
- `vx_i`  in  1  1 = operand A is the scalar `rs1_i` broadcast to all elements.
- `vl_i`  in  $clog2(MAX_VL+1)  active vector length.
- `vs1_i`  in  MAX_VL*ELEN  operand A vector; element k is `[k*ELEN +: ELEN]`.
- `vs2_i`  in  MAX_VL*ELEN  operand B vector.
- `rs1_i`  in  ELEN  scalar operand.
- `out_valid_o`  out  1  result valid.
- `out_ready_i`  in  1  consumer accepts the result.
- `vd_o`  out  MAX_VL*ELEN  result vector.
- `busy_o`  out  1  state is not IDLE.

## Operation
- Element op is `vs2[k] OP a[k]`.
  - `a[k]` is `rs1_i` when `vx` is set; otherwise it is `vs1[k]`.
  - This matches RVV: vs2 is the left operand.
- The block captures `vop`, `vx`, `vl`, the operands, and `rs1` into internal registers on accept. Inputs may change after the accept cycle.
- Effective vl: `vl_i` values above `MAX_VL` clamp to `MAX_VL`.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^ELEN.
  - Shifts use only the low $clog2(ELEN) bits of `a[k]`. SRA sign-extends.
  - SLTS/SLTU write 1 or 0, zero-extended to ELEN.
  - MIN/MAX signed or unsigned, per the opcode.
- REDSUM:
  - `vd[0]` = `a[0]` + sum of `vs2[0..vl-1]`, modulo 2^ELEN.
  - Every other element of `vd` is 0.
  - The accumulator adds `LANES` elements per beat.
  - With `vx` set, `a[0]` is `rs1`.
- Tail: for ordinary ops, elements k ≥ vl are 0 in `vd_o`.
- FSM states:
  - IDLE: `in_ready_o`=1. On `in_valid_i`, the result register is cleared and the beat counter reset to 0. Go to EXEC, or to DONE if vl=0.
  - EXEC: process elements `beat*LANES .. beat*LANES+LANES-1`. Only indices < vl are written. Increment beat; after beat `ceil(vl/LANES)-1`, go to DONE.
  - DONE: `out_valid_o`=1 with `vd_o` stable. On `out_ready_i`, go to IDLE.
- `in_ready_o` is 0 in EXEC and DONE. No new request is accepted in the cycle the result is consumed; IDLE is one cycle long at minimum.
- Reserved opcode 15 runs the normal beat count and writes 0 to all elements.

## Timing
- Reset values:
  - state IDLE, `in_ready_o`=1
  - `out_valid_o`=0, `busy_o`=0
  - `vd_o`=0, beat counter 0
- Reset asserted in any state forces the reset values on the next edge. An in-flight result is discarded and never presented.
- Latency, with the accept edge at cycle T and N = ceil(vl/LANES):
  - EXEC occupies cycles T+1..T+N.
  - `out_valid_o` rises at T+N+1.
  - For vl=0, `out_valid_o` rises at T+1 and `vd_o`=0.
- Output stability: `out_valid_o` stays high and `vd_o` stays stable until the `out_ready_i` handshake. Backpressure of any length is legal.
- Throughput: the next request can be accepted at the earliest one cycle after the output handshake.
- A partial last beat (vl not a multiple of LANES) writes only the lanes below vl. The remaining lanes stay 0.
- `busy_o` is registered and equals (state != IDLE).

## Test plan
- Reset and idle: hold `rst` for 2 cycles → `in_ready_o`=1, `out_valid_o`=0, `vd_o`=0, `busy_o`=0.
- Full-length ADD wrap (LANES=4, MAX_VL=16), `out_ready_i`=1:
  - Stimulus: vl=16, ADD, `vs2[k]`=0xFFFFFFFF, `vs1[k]`=k.
  - Response: `out_valid_o` at T+5; `vd[0]`=0xFFFFFFFF; `vd[k]`=k-1 for k≥1.
- Partial vl, SRA with broadcast:
  - Stimulus: vl=6, SRA, `vx`=1, `rs1`=33 (shift of 1), `vs2[k]`=0x80000000.
  - Response: `vd[0..5]`=0xC0000000, `vd[6..15]`=0, `out_valid_o` at T+3.
- Signed vs unsigned:
  - Stimulus: `vs2[0]`=0xFFFFFFFF, `vs1[0]`=1, vl=1.
  - Response: SLTS→1, SLTU→0, MINS→0xFFFFFFFF, MINU→1.
- REDSUM:
  - Stimulus: vl=5, `vs2[k]`=k+1, `vs1[0]`=10.
  - Response: `vd[0]`=25 and all other elements 0.
- Backpressure and reset:
  1. With vl=0, `out_ready_i` held at 0 for 10 cycles → `out_valid_o` stays 1, `vd_o` stays 0, and `in_valid_i` is ignored.
  2. Start vl=16, then assert `rst` during EXEC beat 2 → next cycle IDLE with `out_valid_o`=0 for the next 10 cycles.

Source files
------------

// File: rtl/zeroriscy_vec_alu.sv
// Multi-cycle vector ALU: accepts one vector op, runs ceil(vl/LANES) beats of LANES
// elements each, then holds the result until the writeback stage takes it.
module zeroriscy_vec_alu #(
   parameter int unsigned LANES  = 4,
   parameter int unsigned ELEN   = 32,
   parameter int unsigned MAX_VL = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   input  logic [3:0]                   vop_i,
   input  logic                         vx_i,
   input  logic [$clog2(MAX_VL+1)-1:0]  vl_i,
   input  logic [MAX_VL*ELEN-1:0]       vs1_i,
   input  logic [MAX_VL*ELEN-1:0]       vs2_i,
   input  logic [ELEN-1:0]              rs1_i,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic [MAX_VL*ELEN-1:0]       vd_o,
   output logic                         busy_o
);

   localparam int unsigned VLW = $clog2(MAX_VL + 1);
   localparam int unsigned BW  = $clog2(MAX_VL / LANES + 1);
   localparam int unsigned SHW = $clog2(ELEN);
   localparam logic [VLW-1:0] MAX_VL_W = VLW'(MAX_VL);

   typedef logic [ELEN-1:0] elem_t;
   typedef logic [MAX_VL-1:0][ELEN-1:0] vec_t;
   typedef logic [LANES-1:0][ELEN-1:0] lane_vec_t;

   typedef enum logic [3:0] {
      OpAdd, OpSub, OpAnd, OpOr, OpXor, OpSll, OpSrl, OpSra,
      OpSlts, OpSltu, OpMins, OpMaxs, OpMinu, OpMaxu, OpRedsum, OpRsvd
   } op_e;

   typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

   state_e          state_q, state_d;
   logic [BW-1:0]   beat_q, beat_d;
   op_e             op_q;
   logic            vx_q;
   logic [VLW-1:0]  vl_q, vl_eff;
   vec_t            vs1_q, vs2_q, vd_q, vd_d;
   elem_t           rs1_q, a0, red_sum;
   lane_vec_t       lane_a, lane_b;
   logic            accept, last_beat, busy_q;

   function automatic elem_t elem_op(input op_e op, input elem_t b, input elem_t a);
      logic [SHW-1:0] sh;
      elem_t          res;
      sh  = a[SHW-1:0];
      res = '0;
      case (op)
         OpAdd:  res = b + a;
         OpSub:  res = b - a;
         OpAnd:  res = b & a;
         OpOr:   res = b | a;
         OpXor:  res = b ^ a;
         OpSll:  res = b << sh;
         OpSrl:  res = b >> sh;
         OpSra:  res = elem_t'($signed(b) >>> sh);
         OpSlts: res = elem_t'($signed(b) < $signed(a));
         OpSltu: res = elem_t'(b < a);
         OpMins: res = ($signed(b) < $signed(a)) ? b : a;
         OpMaxs: res = ($signed(b) < $signed(a)) ? a : b;
         OpMinu: res = (b < a) ? b : a;
         OpMaxu: res = (b < a) ? a : b;
         default: res = '0;
      endcase
      return res;
   endfunction

   assign vl_eff    = (vl_i > MAX_VL_W) ? MAX_VL_W : vl_i;
   assign accept    = in_ready_o && in_valid_i;
   assign last_beat = ((32'(beat_q) + 1) * LANES) >= 32'(vl_q);
   assign a0        = vx_q ? rs1_q : vs1_q[0];

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d != StIdle);
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: if (in_valid_i) state_d = (vl_eff == '0) ? StDone : StExec;
         StExec: if (last_beat) state_d = StDone;
         StDone: if (out_ready_i) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // FSM: outputs
   always_comb begin
      in_ready_o  = (state_q == StIdle);
      out_valid_o = (state_q == StDone);
   end

   // Route the current beat's elements onto the LANES datapath slots.
   always_comb begin
      lane_a = '0;
      lane_b = '0;
      for (int unsigned k = 0; k < MAX_VL; k++) begin
         if (k / LANES == 32'(beat_q)) begin
            lane_b[k % LANES] = vs2_q[k];
            lane_a[k % LANES] = vx_q ? rs1_q : vs1_q[k];
         end
      end
   end

   always_comb begin
      red_sum = (beat_q == '0) ? a0 : vd_q[0];
      for (int unsigned l = 0; l < LANES; l++) begin
         if (32'(beat_q) * LANES + l < 32'(vl_q)) red_sum = red_sum + lane_b[l];
      end
   end

   always_comb begin
      vd_d   = vd_q;
      beat_d = beat_q;
      case (state_q)
         StIdle: begin
            if (in_valid_i) begin
               vd_d   = '0;
               beat_d = '0;
            end
         end
         StExec: begin
            beat_d = beat_q + 1'b1;
            if (op_q == OpRedsum) begin
               vd_d[0] = red_sum;
            end else begin
               for (int unsigned k = 0; k < MAX_VL; k++) begin
                  if (k / LANES == 32'(beat_q) && k < 32'(vl_q)) begin
                     vd_d[k] = elem_op(op_q, lane_b[k % LANES], lane_a[k % LANES]);
                  end
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         beat_q <= '0;
         vd_q   <= '0;
         op_q   <= OpAdd;
         vx_q   <= 1'b0;
         vl_q   <= '0;
         vs1_q  <= '0;
         vs2_q  <= '0;
         rs1_q  <= '0;
      end else begin
         beat_q <= beat_d;
         vd_q   <= vd_d;
         if (accept) begin
            op_q  <= op_e'(vop_i);
            vx_q  <= vx_i;
            vl_q  <= vl_eff;
            vs1_q <= vs1_i;
            vs2_q <= vs2_i;
            rs1_q <= rs1_i;
         end
      end
   end

   assign vd_o   = vd_q;
   assign busy_o = busy_q;

endmodule
